core_lsu_wbuf: RTL and testbench

// - Parametrised store/write buffer between the M2 LSU stage and the dram manager write port.
// - Decouples committed stores from we_ready back-pressure, so M2 no longer stalls per store.
// - Merges byte-strobed cached stores to the same word and forwards buffered bytes to younger loads.
// - Drains strictly in program order; uncached stores are never merged.

---
 rtl/core_lsu_wbuf_if.sv | 31 +++
 rtl/core_lsu_wbuf.sv | 116 +++++++++++
 tb/tb_core_lsu_wbuf.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/core_lsu_wbuf_if.sv
// Store-buffer bus bundle: M2 store-commit push channel and dram manager write channel.
// slave is the buffer; master is the LSU/dram-manager side.
interface core_lsu_wbuf_if;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_addr_i;
  logic [31:0] push_wdata_i;
  logic [3:0]  push_strobe_i;
  logic        push_uncached_i;

  logic        dm_we_valid_o;
  logic        dm_we_ready_i;
  logic [31:0] dm_addr_o;
  logic [31:0] dm_wdata_o;
  logic [3:0]  dm_strobe_o;
  logic        dm_uncached_o;

  modport slave (
    input  push_valid_i, push_addr_i, push_wdata_i, push_strobe_i, push_uncached_i,
    output push_ready_o,
    output dm_we_valid_o, dm_addr_o, dm_wdata_o, dm_strobe_o, dm_uncached_o,
    input  dm_we_ready_i
  );

  modport master (
    output push_valid_i, push_addr_i, push_wdata_i, push_strobe_i, push_uncached_i,
    input  push_ready_o,
    input  dm_we_valid_o, dm_addr_o, dm_wdata_o, dm_strobe_o, dm_uncached_o,
    output dm_we_ready_i
  );
endinterface

// File: rtl/core_lsu_wbuf.sv
// In-order store/write buffer between M2 and the dram manager write port, with
// same-word merging of cached stores and byte-granular forwarding to younger loads.
module core_lsu_wbuf #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          MERGE_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  core_lsu_wbuf_if.slave           bus,
  input  logic [31:0]              fwd_addr_i,
  output logic [3:0]               fwd_strobe_o,
  output logic [31:0]              fwd_data_o,
  output logic                     fwd_conflict_o,
  input  logic                     flush_i,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   TWO_CNT  = (AW+1)'(2);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  logic [AW:0]   head_q, tail_q;
  logic [AW-1:0] head_idx, tail_idx, young_idx, fwd_idx;

  logic [29:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  strb_q [DEPTH];
  logic        unc_q  [DEPTH];

  logic full, merge_hit, push_fire, alloc_fire, merge_fire, pop_fire;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{bus.push_addr_i[1:0], fwd_addr_i[1:0]};

  assign head_idx  = head_q[AW-1:0];
  assign tail_idx  = tail_q[AW-1:0];
  assign young_idx = tail_idx - IDX_ONE;

  assign count_o = tail_q - head_q;
  assign empty_o = (count_o == '0);
  assign full    = (count_o == FULL_CNT);

  // count>=2 keeps the head, which may be mid-handshake, out of the merge target set
  assign merge_hit = MERGE_EN && !bus.push_uncached_i && (count_o >= TWO_CNT) &&
                     !unc_q[young_idx] && (addr_q[young_idx] == bus.push_addr_i[31:2]);

  assign bus.push_ready_o = !flush_i && (!full || merge_hit);

  assign push_fire  = bus.push_valid_i && bus.push_ready_o;
  assign merge_fire = push_fire && merge_hit;
  assign alloc_fire = push_fire && !merge_hit;

  assign bus.dm_we_valid_o = !empty_o;
  assign bus.dm_addr_o     = {addr_q[head_idx], 2'b00};
  assign bus.dm_wdata_o    = data_q[head_idx];
  assign bus.dm_strobe_o   = strb_q[head_idx];
  assign bus.dm_uncached_o = unc_q[head_idx];
  assign pop_fire          = bus.dm_we_valid_o && bus.dm_we_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
        unc_q[i]  <= 1'b0;
      end
    end else begin
      if (alloc_fire) begin
        addr_q[tail_idx] <= bus.push_addr_i[31:2];
        data_q[tail_idx] <= bus.push_wdata_i;
        strb_q[tail_idx] <= bus.push_strobe_i;
        unc_q[tail_idx]  <= bus.push_uncached_i;
        tail_q           <= tail_q + PTR_ONE;
      end
      if (merge_fire) begin
        strb_q[young_idx] <= strb_q[young_idx] | bus.push_strobe_i;
        for (int unsigned b = 0; b < 4; b++) begin
          if (bus.push_strobe_i[b]) begin
            data_q[young_idx][8*b +: 8] <= bus.push_wdata_i[8*b +: 8];
          end
        end
      end
      if (pop_fire) begin
        head_q <= head_q + PTR_ONE;
      end
    end
  end

  // Walk oldest to youngest so later (younger) writers override earlier bytes
  always_comb begin
    fwd_strobe_o   = '0;
    fwd_data_o     = '0;
    fwd_conflict_o = 1'b0;
    fwd_idx        = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = head_idx + AW'(k);
      if ((k < 32'(count_o)) && (addr_q[fwd_idx] == fwd_addr_i[31:2])) begin
        if (unc_q[fwd_idx]) begin
          fwd_conflict_o = 1'b1;
        end else begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (strb_q[fwd_idx][b]) begin
              fwd_strobe_o[b]         = 1'b1;
              fwd_data_o[8*b +: 8]    = data_q[fwd_idx][8*b +: 8];
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_core_lsu_wbuf.sv
// Directed self-checking bench for core_lsu_wbuf (DEPTH=4, MERGE_EN=1).
module tb_core_lsu_wbuf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fwd_addr_i = '0;
  logic [3:0]  fwd_strobe_o;
  logic [31:0] fwd_data_o;
  logic        fwd_conflict_o;
  logic        flush_i = 1'b0;
  logic        empty_o;
  logic [2:0]  count_o;
  int          n_checks = 0;
  int          n_fail = 0;

  core_lsu_wbuf_if bus ();

  core_lsu_wbuf #(.DEPTH(4), .MERGE_EN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .fwd_addr_i     (fwd_addr_i),
    .fwd_strobe_o   (fwd_strobe_o),
    .fwd_data_o     (fwd_data_o),
    .fwd_conflict_o (fwd_conflict_o),
    .flush_i        (flush_i),
    .empty_o        (empty_o),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic u);
    bus.push_valid_i    = 1'b1;
    bus.push_addr_i     = a;
    bus.push_wdata_i    = d;
    bus.push_strobe_i   = s;
    bus.push_uncached_i = u;
    tick();
    bus.push_valid_i    = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fwd_addr_i = 32'h0000_1000;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.dm_we_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.dm_we_valid_o); end
    n_checks++; if (bus.push_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.push_ready_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_checks++; if ({fwd_strobe_o, fwd_data_o, fwd_conflict_o} !== 37'd0) begin n_fail++; $display("FAIL reset_fwd: got %h/%h/%b want 0", fwd_strobe_o, fwd_data_o, fwd_conflict_o); end
  endtask

  task automatic test_single();
    bus.dm_we_ready_i = 1'b0;
    push(32'h0000_1000, 32'h1122_3344, 4'b1111, 1'b0);
    n_checks++; if (bus.dm_we_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.dm_we_valid_o); end
    n_checks++; if (bus.dm_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL single_addr: got %h want 00001000", bus.dm_addr_o); end
    n_checks++; if (bus.dm_wdata_o !== 32'h1122_3344) begin n_fail++; $display("FAIL single_data: got %h want 11223344", bus.dm_wdata_o); end
    n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count_o); end
    tick();
    n_checks++; if (bus.dm_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL single_stable: got %h want 00001000", bus.dm_addr_o); end
    bus.dm_we_ready_i = 1'b1;
    tick();
    bus.dm_we_ready_i = 1'b0;
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL single_drain_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_merge();
    push(32'h0000_2000, 32'h0000_00AA, 4'b0001, 1'b0);
    push(32'h0000_3000, 32'h5566_7788, 4'b1111, 1'b0);
    bus.push_valid_i = 1'b1; bus.push_addr_i = 32'h0000_3001; bus.push_wdata_i = 32'h0000_BB00;
    bus.push_strobe_i = 4'b0010; bus.push_uncached_i = 1'b0;
    #1;
    n_checks++; if (bus.push_ready_o !== 1'b1) begin n_fail++; $display("FAIL merge_ready: got %b want 1", bus.push_ready_o); end
    tick();
    bus.push_valid_i = 1'b0;
    fwd_addr_i = 32'h0000_3000;
    #1;
    n_checks++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL merge_count: got %0d want 2", count_o); end
    n_checks++; if (fwd_strobe_o !== 4'b1111) begin n_fail++; $display("FAIL merge_fwd_strobe: got %b want 1111", fwd_strobe_o); end
    n_checks++; if (fwd_data_o !== 32'h5566_BB88) begin n_fail++; $display("FAIL merge_fwd_data: got %h want 5566bb88", fwd_data_o); end
    bus.dm_we_ready_i = 1'b1;
    #1;
    n_checks++; if ({bus.dm_addr_o, bus.dm_wdata_o, bus.dm_strobe_o} !== {32'h0000_2000, 32'h0000_00AA, 4'b0001}) begin n_fail++; $display("FAIL merge_drain0: got %h %h %b want 00002000 000000aa 0001", bus.dm_addr_o, bus.dm_wdata_o, bus.dm_strobe_o); end
    tick();
    n_checks++; if ({bus.dm_addr_o, bus.dm_wdata_o, bus.dm_strobe_o} !== {32'h0000_3000, 32'h5566_BB88, 4'b1111}) begin n_fail++; $display("FAIL merge_drain1: got %h %h %b want 00003000 5566bb88 1111", bus.dm_addr_o, bus.dm_wdata_o, bus.dm_strobe_o); end
    tick();
    bus.dm_we_ready_i = 1'b0;
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL merge_empty: got %b want 1", empty_o); end
    // a single entry is the head and must not absorb a same-word push
    push(32'h0000_5000, 32'h0000_0011, 4'b0001, 1'b0);
    push(32'h0000_5000, 32'h0000_2200, 4'b0010, 1'b0);
    n_checks++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL nomerge_head_count: got %0d want 2", count_o); end
    push(32'h0000_5000, 32'h0000_0000, 4'b0100, 1'b1);
    push(32'h0000_5000, 32'h0000_0000, 4'b1000, 1'b0);
    n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL nomerge_unc_count: got %0d want 4", count_o); end
    bus.dm_we_ready_i = 1'b1;
    tick(); tick(); tick(); tick();
    bus.dm_we_ready_i = 1'b0;
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL nomerge_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_full();
    push(32'h0000_0100, 32'h0000_0001, 4'b1111, 1'b0);
    push(32'h0000_0200, 32'h0000_0002, 4'b1111, 1'b0);
    push(32'h0000_0300, 32'h0000_0003, 4'b1111, 1'b0);
    push(32'h0000_0400, 32'h0000_0004, 4'b1111, 1'b0);
    n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count_o); end
    bus.push_valid_i = 1'b1; bus.push_addr_i = 32'h0000_0800; bus.push_wdata_i = 32'h0;
    bus.push_strobe_i = 4'b1111; bus.push_uncached_i = 1'b0;
    #1;
    n_checks++; if (bus.push_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready_miss: got %b want 0", bus.push_ready_o); end
    bus.push_addr_i = 32'h0000_0400; bus.push_uncached_i = 1'b1;
    #1;
    n_checks++; if (bus.push_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready_unc: got %b want 0", bus.push_ready_o); end
    bus.push_uncached_i = 1'b0; bus.push_wdata_i = 32'h00EE_0000; bus.push_strobe_i = 4'b0100;
    #1;
    n_checks++; if (bus.push_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_merge: got %b want 1", bus.push_ready_o); end
    tick();
    n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_merge_count: got %0d want 4", count_o); end
    bus.push_addr_i = 32'h0000_0800; bus.push_strobe_i = 4'b1111;
    bus.dm_we_ready_i = 1'b1;
    #1;
    n_checks++; if (bus.push_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready: got %b want 0", bus.push_ready_o); end
    tick();
    bus.push_valid_i = 1'b0;
    #1;
    n_checks++; if ({count_o, bus.dm_addr_o} !== {3'd3, 32'h0000_0200}) begin n_fail++; $display("FAIL full_drain1: got %0d %h want 3 00000200", count_o, bus.dm_addr_o); end
    tick();
    n_checks++; if (bus.dm_addr_o !== 32'h0000_0300) begin n_fail++; $display("FAIL full_drain2: got %h want 00000300", bus.dm_addr_o); end
    tick();
    n_checks++; if ({bus.dm_addr_o, bus.dm_wdata_o} !== {32'h0000_0400, 32'h00EE_0004}) begin n_fail++; $display("FAIL full_drain3: got %h %h want 00000400 00ee0004", bus.dm_addr_o, bus.dm_wdata_o); end
    tick();
    bus.dm_we_ready_i = 1'b0;
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL full_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_forward();
    push(32'h0000_4000, 32'h0000_1122, 4'b0011, 1'b0);
    push(32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    fwd_addr_i = 32'h0000_4002;
    #1;
    n_checks++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL fwd_count: got %0d want 2", count_o); end
    n_checks++; if ({fwd_strobe_o, fwd_data_o, fwd_conflict_o} !== {4'b0011, 32'h0000_1122, 1'b1}) begin n_fail++; $display("FAIL fwd_unc: got %b %h %b want 0011 00001122 1", fwd_strobe_o, fwd_data_o, fwd_conflict_o); end
    push(32'h0000_4000, 32'h00AA_BB00, 4'b0110, 1'b0);
    n_checks++; if ({fwd_strobe_o, fwd_data_o, fwd_conflict_o} !== {4'b0111, 32'h00AA_BB22, 1'b1}) begin n_fail++; $display("FAIL fwd_youngest: got %b %h %b want 0111 00aabb22 1", fwd_strobe_o, fwd_data_o, fwd_conflict_o); end
    fwd_addr_i = 32'h0000_5000;
    #1;
    n_checks++; if ({fwd_strobe_o, fwd_data_o, fwd_conflict_o} !== 37'd0) begin n_fail++; $display("FAIL fwd_miss: got %b %h %b want 0", fwd_strobe_o, fwd_data_o, fwd_conflict_o); end
  endtask

  task automatic test_flush();
    logic [2:0] want;
    flush_i = 1'b1;
    bus.dm_we_ready_i = 1'b1;
    bus.push_valid_i = 1'b1; bus.push_addr_i = 32'h0000_9000; bus.push_wdata_i = 32'h0;
    bus.push_strobe_i = 4'b1111; bus.push_uncached_i = 1'b0;
    want = 3'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.push_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready%0d: got %b want 0", i, bus.push_ready_o); end
      tick();
      want = want - 3'd1;
      n_checks++; if (count_o !== want) begin n_fail++; $display("FAIL flush_count%0d: got %0d want %0d", i, count_o, want); end
    end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", empty_o); end
    bus.push_valid_i = 1'b0;
    bus.dm_we_ready_i = 1'b0;
    flush_i = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    push(32'h0000_A000, 32'h1, 4'b1111, 1'b0);
    push(32'h0000_B000, 32'h2, 4'b1111, 1'b0);
    push(32'h0000_C000, 32'h3, 4'b1111, 1'b0);
    bus.dm_we_ready_i = 1'b1;
    #1;
    n_checks++; if ({bus.dm_we_valid_o, count_o} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL rstmid_pre: got %b %0d want 1 3", bus.dm_we_valid_o, count_o); end
    rst_n = 1'b0;
    tick();
    n_checks++; if ({bus.dm_we_valid_o, count_o} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL rstmid_post: got %b %0d want 0 0", bus.dm_we_valid_o, count_o); end
    rst_n = 1'b1;
    tick();
    bus.dm_we_ready_i = 1'b0;
    n_checks++; if ({bus.dm_we_valid_o, empty_o} !== {1'b0, 1'b1}) begin n_fail++; $display("FAIL rstmid_after: got %b %b want 0 1", bus.dm_we_valid_o, empty_o); end
  endtask

  initial begin
    bus.push_valid_i = 1'b0;
    bus.push_addr_i = '0;
    bus.push_wdata_i = '0;
    bus.push_strobe_i = '0;
    bus.push_uncached_i = 1'b0;
    bus.dm_we_ready_i = 1'b0;
    test_reset();
    test_single();
    test_merge();
    test_full();
    test_forward();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
